// File: rtl/midi_pkg.sv
// Shared MIDI constants, event layout and FSM encoding.
// Used by the TX encoder and the far-end parser.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_OFF    = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON     = 8'h90;
  localparam logic [7:0] MIDI_STATUS_MASK = 8'hF0;

  localparam int MIDI_EVT_W = 15;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note;
    logic [6:0] vel;
  } midi_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_ST,
    ST_WAIT_ST,
    ST_SEND_D1,
    ST_WAIT_D1,
    ST_SEND_D2,
    ST_WAIT_D2
  } midi_state_e;

  function automatic logic [7:0] midi_status(
    input logic       note_on,
    input logic [3:0] ch
  );
    logic [7:0] base;
    base = note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF;
    return (base & MIDI_STATUS_MASK) | {4'h0, ch};
  endfunction

endpackage

// File: rtl/midi_tx_encoder_if.sv
// Event valid/ready port plus UART TX byte handshake.
// master = producer/UART side, slave = encoder.
interface midi_tx_encoder_if;

  logic       evt_valid;
  logic       evt_ready;
  logic       evt_note_on;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output evt_valid, evt_note_on, evt_note, evt_vel,
    output tx_active, tx_done,
    input  evt_ready, tx_dv, tx_byte
  );

  modport slave (
    input  evt_valid, evt_note_on, evt_note, evt_vel,
    input  tx_active, tx_done,
    output evt_ready, tx_dv, tx_byte
  );

endinterface

// File: rtl/midi_evt_fifo.sv
// Synchronous event FIFO, no fall-through.
// Flags come straight from the occupancy register.
module midi_evt_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = MIDI_EVT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)
        count <= count + 1'b1;
      else if (rd_en && !wr_en)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/midi_tx_encoder.sv
// Event FIFO -> 3-byte MIDI channel message -> UART TX.
// `MIDI_RUNNING_STATUS_EN drops repeated status bytes.
module midi_tx_encoder
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic               clk,
  input  logic               rst,
  midi_tx_encoder_if.slave   bus,
  output logic               busy
);

  localparam logic [3:0] CH = 4'(MIDI_CHANNEL);

  midi_state_e state;
  midi_state_e state_nx;

  midi_evt_t             in_evt;
  midi_evt_t             head;
  midi_evt_t             cur;
  logic [MIDI_EVT_W-1:0] fifo_dout;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  skip_st;
  logic [7:0]            head_st;
  logic [7:0]            cur_st;

  assign in_evt = {bus.evt_note_on, bus.evt_note, bus.evt_vel};
  assign head   = fifo_dout;
  assign pop    = (state == ST_IDLE) && !empty;

  assign head_st = midi_status(head.note_on, CH);
  assign cur_st  = midi_status(cur.note_on, CH);

  assign bus.evt_ready = !full;
  assign busy          = (state != ST_IDLE) || !empty;

  midi_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MIDI_EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.evt_valid),
    .din   (in_evt),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

`ifdef MIDI_RUNNING_STATUS_EN
  // 8'h00 is never a valid status, so the first message always sends one
  logic [7:0] last_status;

  always_ff @(posedge clk) begin
    if (rst)
      last_status <= 8'h00;
    else if (state == ST_SEND_ST && bus.tx_dv)
      last_status <= cur_st;
  end

  assign skip_st = (head_st == last_status);
`else
  assign skip_st = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nx;
      if (pop) cur <= head;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (!empty)
          state_nx = skip_st ? ST_SEND_D1 : ST_SEND_ST;
      ST_SEND_ST:
        if (!bus.tx_active) state_nx = ST_WAIT_ST;
      ST_WAIT_ST:
        if (bus.tx_done) state_nx = ST_SEND_D1;
      ST_SEND_D1:
        if (!bus.tx_active) state_nx = ST_WAIT_D1;
      ST_WAIT_D1:
        if (bus.tx_done) state_nx = ST_SEND_D2;
      ST_SEND_D2:
        if (!bus.tx_active) state_nx = ST_WAIT_D2;
      ST_WAIT_D2:
        if (bus.tx_done) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_dv   = 1'b0;
    bus.tx_byte = 8'h00;
    unique case (state)
      ST_SEND_ST: begin
        bus.tx_dv   = !bus.tx_active;
        bus.tx_byte = cur_st;
      end
      ST_SEND_D1: begin
        bus.tx_dv   = !bus.tx_active;
        bus.tx_byte = {1'b0, cur.note};
      end
      ST_SEND_D2: begin
        bus.tx_dv   = !bus.tx_active;
        bus.tx_byte = {1'b0, cur.vel};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Directed bench for midi_tx_encoder with a simple UART TX model.
// Honours `MIDI_RUNNING_STATUS_EN for the running-status vectors.
module tb_midi_tx_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  midi_tx_encoder_if b0 ();
  midi_tx_encoder_if b3 ();
  logic busy0;
  logic busy3;

  midi_tx_encoder #(.FIFO_DEPTH(4), .MIDI_CHANNEL(0)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave), .busy (busy0)
  );

  midi_tx_encoder #(.FIFO_DEPTH(4), .MIDI_CHANNEL(3)) dut3 (
    .clk (clk), .rst (rst), .bus (b3.slave), .busy (busy3)
  );

  // UART model: active one cycle after tx_dv, done pulse 10 cycles later
  logic m0_act = 0, m0_done = 0, hold0 = 0, spur0 = 0;
  int   m0_cnt = 0;
  logic m3_act = 0, m3_done = 0;
  int   m3_cnt = 0;

  assign b0.tx_active = m0_act | hold0;
  assign b0.tx_done   = m0_done | spur0;
  assign b3.tx_active = m3_act;
  assign b3.tx_done   = m3_done;

  always @(posedge clk) begin
    m0_done <= 1'b0;
    if (b0.tx_dv && !m0_act) begin
      m0_act <= 1'b1;
      m0_cnt <= 10;
    end else if (m0_act) begin
      if (m0_cnt == 1) begin
        m0_act  <= 1'b0;
        m0_done <= 1'b1;
      end
      m0_cnt <= m0_cnt - 1;
    end
  end

  always @(posedge clk) begin
    m3_done <= 1'b0;
    if (b3.tx_dv && !m3_act) begin
      m3_act <= 1'b1;
      m3_cnt <= 10;
    end else if (m3_act) begin
      if (m3_cnt == 1) begin
        m3_act  <= 1'b0;
        m3_done <= 1'b1;
      end
      m3_cnt <= m3_cnt - 1;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic prev_dv0 = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (b0.tx_dv) begin
      q0.push_back(b0.tx_byte);
      chk("dv_while_active", 32'(b0.tx_active), 0);
      chk("dv_one_cycle", 32'(prev_dv0), 0);
    end
    if (b3.tx_dv) q3.push_back(b3.tx_byte);
    prev_dv0 = b0.tx_dv;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push0(logic on, logic [6:0] note, logic [6:0] vel);
    int k = 0;
    b0.evt_valid   = 1'b1;
    b0.evt_note_on = on;
    b0.evt_note    = note;
    b0.evt_vel     = vel;
    while (!b0.evt_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("push_timeout", 32'(b0.evt_ready), 1);
    @(negedge clk);
    b0.evt_valid = 1'b0;
  endtask

  task automatic wait_q0(int n);
    int k = 0;
    while (q0.size() < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("bytes_timeout", 32'(q0.size() >= n), 1);
  endtask

  task automatic wait_idle0();
    int k = 0;
    while (busy0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy0), 0);
  endtask

  task automatic cmp_q0(string tag, input logic [7:0] e[$]);
    chk({tag, "_len"}, q0.size(), e.size());
    foreach (e[i])
      if (i < q0.size()) chk(tag, 32'(q0[i]), 32'(e[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    int k;
    b0.evt_valid = 0; b0.evt_note_on = 0; b0.evt_note = 0; b0.evt_vel = 0;
    b3.evt_valid = 0; b3.evt_note_on = 0; b3.evt_note = 0; b3.evt_vel = 0;

    do_reset();
    chk("rst_ready", 32'(b0.evt_ready), 1);
    chk("rst_dv", 32'(b0.tx_dv), 0);
    chk("rst_byte", 32'(b0.tx_byte), 0);
    chk("rst_busy", 32'(busy0), 0);

    // 1: note on 60/100, ch0, latency to status strobe
    push0(1'b1, 7'd60, 7'd100);
    chk("lat_n1_dv", 32'(b0.tx_dv), 0);
    chk("lat_n1_busy", 32'(busy0), 1);
    @(negedge clk);
    chk("lat_n2_dv", 32'(b0.tx_dv), 1);
    chk("lat_n2_byte", 32'(b0.tx_byte), 32'h90);
    wait_q0(3);
    e = '{8'h90, 8'h3C, 8'h64};
    cmp_q0("t1", e);
    wait_idle0();

    // 2: note off 60/0x40 on channel 3, busy timing
    b3.evt_valid = 1; b3.evt_note_on = 0;
    b3.evt_note = 7'd60; b3.evt_vel = 7'h40;
    @(negedge clk);
    b3.evt_valid = 0;
    k = 0;
    while (!(b3.tx_done && q3.size() == 3) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t2_done_seen", 32'(k < 1000), 1);
    chk("t2_busy_at_done", 32'(busy3), 1);
    @(negedge clk);
    chk("t2_busy_after", 32'(busy3), 0);
    chk("t2_len", q3.size(), 3);
    if (q3.size() == 3) begin
      chk("t2_b0", 32'(q3[0]), 32'h83);
      chk("t2_b1", 32'(q3[1]), 32'h3C);
      chk("t2_b2", 32'(q3[2]), 32'h40);
    end

    // 3: UART stalled, fill FIFO behind an in-flight message
    do_reset();
    q0.delete();
    hold0 = 1'b1;
    push0(1'b1, 7'd60, 7'd1);
    @(negedge clk);
    chk("t3_held_dv", 32'(b0.tx_dv), 0);
    for (int i = 1; i <= 4; i++)
      push0(i[0] == 1'b0, 7'(60 + i), 7'(i + 1));
    chk("t3_full_ready", 32'(b0.evt_ready), 0);
    fork
      push0(1'b0, 7'd65, 7'd6);
      begin
        repeat (4) @(negedge clk);
        chk("t3_still_full", 32'(b0.evt_ready), 0);
        hold0 = 1'b0;
      end
    join
    wait_q0(18);
    e = {};
    for (int i = 0; i < 6; i++) begin
      e.push_back(i[0] ? 8'h80 : 8'h90);
      e.push_back(8'(60 + i));
      e.push_back(8'(i + 1));
    end
    cmp_q0("t3", e);
    wait_idle0();

    // 4: running status vs full status
    do_reset();
    q0.delete();
    push0(1'b1, 7'd60, 7'd100);
    push0(1'b1, 7'd62, 7'd100);
    push0(1'b0, 7'd60, 7'h40);
`ifdef MIDI_RUNNING_STATUS_EN
    e = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'h80, 8'h3C, 8'h40};
`else
    e = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64,
          8'h80, 8'h3C, 8'h40};
`endif
    wait_q0(e.size());
    cmp_q0("t4", e);
    wait_idle0();

    // 5: reset while waiting for the D1 frame
    q0.delete();
    push0(1'b1, 7'd60, 7'd100);
    push0(1'b1, 7'd61, 7'd100);
    wait_q0(2);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_dv", 32'(b0.tx_dv), 0);
    chk("t5_ready", 32'(b0.evt_ready), 1);
    chk("t5_busy", 32'(busy0), 0);
    rst = 1'b0;
    q0.delete();
    push0(1'b1, 7'd62, 7'd100);
    wait_q0(3);
    e = '{8'h90, 8'h3E, 8'h64};
    cmp_q0("t5", e);
    wait_idle0();

    // 6: tx_active withholds tx_dv; vel 0 sent as-is; stray tx_done
    do_reset();
    q0.delete();
    hold0 = 1'b1;
    push0(1'b1, 7'd64, 7'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_withheld", 32'(b0.tx_dv), 0);
      chk("t6_busy", 32'(busy0), 1);
    end
    hold0 = 1'b0;
    wait_q0(3);
    e = '{8'h90, 8'h40, 8'h00};
    cmp_q0("t6", e);
    wait_idle0();
    spur0 = 1'b1;
    @(negedge clk);
    spur0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_spur_busy", 32'(busy0), 0);
    chk("t6_spur_bytes", q0.size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
